// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake; single-cycle ops plus an iterative signed multiply.
// Optional multiplier (MUL state, shift-add datapath) is built only when ALU_MULT_EN is defined.
module alu_seq #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_OP-1:0]   i_operation_code,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_overflow,
    output logic               o_zero
);

    localparam logic [NB_OP-1:0] OP_ADD  = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB  = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND  = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR   = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR  = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR  = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SLL  = NB_OP'(6'b000000);
    localparam logic [NB_OP-1:0] OP_SRL  = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0] OP_SRA  = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_SLT  = NB_OP'(6'b101010);
    localparam logic [NB_OP-1:0] OP_SLTU = NB_OP'(6'b101011);

    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic [NB_DATA-1:0] result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic               accept_c;
    logic               shift_big_c;
    logic [NB_DATA-1:0] alu_r_c;
    logic               alu_ovf_c;

    assign accept_c    = i_valid && ready_q;
    assign shift_big_c = (i_data_b >= NB_DATA'(NB_DATA));

    // Single-cycle operations, evaluated straight from the request inputs
    always_comb begin
        alu_r_c   = '0;
        alu_ovf_c = 1'b0;
        case (i_operation_code)
            OP_ADD: begin
                alu_r_c   = i_data_a + i_data_b;
                alu_ovf_c = (i_data_a[NB_DATA-1] == i_data_b[NB_DATA-1]) &&
                            (alu_r_c[NB_DATA-1] != i_data_a[NB_DATA-1]);
            end
            OP_SUB: begin
                alu_r_c   = i_data_a - i_data_b;
                alu_ovf_c = (i_data_a[NB_DATA-1] != i_data_b[NB_DATA-1]) &&
                            (alu_r_c[NB_DATA-1] != i_data_a[NB_DATA-1]);
            end
            OP_AND:  alu_r_c = i_data_a & i_data_b;
            OP_OR:   alu_r_c = i_data_a | i_data_b;
            OP_XOR:  alu_r_c = i_data_a ^ i_data_b;
            OP_NOR:  alu_r_c = ~(i_data_a | i_data_b);
            OP_SLL:  alu_r_c = shift_big_c ? '0 : (i_data_a << i_data_b);
            OP_SRL:  alu_r_c = shift_big_c ? '0 : (i_data_a >> i_data_b);
            OP_SRA:  alu_r_c = shift_big_c ? {NB_DATA{i_data_a[NB_DATA-1]}}
                                           : NB_DATA'($signed(i_data_a) >>> i_data_b);
            OP_SLT:  alu_r_c = NB_DATA'($signed(i_data_a) < $signed(i_data_b));
            OP_SLTU: alu_r_c = NB_DATA'(i_data_a < i_data_b);
            default: ;
        endcase
    end

`ifdef ALU_MULT_EN
    localparam logic [NB_OP-1:0] OP_MULT = NB_OP'(6'b011000);
    localparam int unsigned      NB_PROD = 2 * NB_DATA;
    localparam int unsigned      NB_CNT  = $clog2(NB_DATA);
    localparam logic [NB_CNT-1:0] LAST   = NB_CNT'(NB_DATA - 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state_q, state_d;
    logic [NB_PROD-1:0] acc_q, acc_d;
    logic [NB_PROD-1:0] mcand_q, mcand_d;
    logic [NB_DATA-1:0] mplier_q, mplier_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    logic [NB_PROD-1:0] addend_c;
    logic [NB_PROD-1:0] acc_next_c;

    // Multiplier sign bit carries weight -2^(N-1), so the last partial product is subtracted
    assign addend_c   = !mplier_q[0]     ? '0 :
                        (cnt_q == LAST)  ? -mcand_q : mcand_q;
    assign acc_next_c = acc_q + addend_c;

    always_comb begin
        state_d  = state_q;
        ready_d  = 1'b1;
        valid_d  = 1'b0;
        result_d = result_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (i_operation_code == OP_MULT) begin
                        state_d  = S_MUL;
                        ready_d  = 1'b0;
                        acc_d    = '0;
                        mcand_d  = NB_PROD'($signed(i_data_a));
                        mplier_d = i_data_b;
                        cnt_d    = '0;
                    end else begin
                        valid_d  = 1'b1;
                        result_d = alu_r_c;
                        ovf_d    = alu_ovf_c;
                        zero_d   = (alu_r_c == '0);
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_next_c;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + NB_CNT'(1);
                if (cnt_q == LAST) begin
                    state_d  = S_IDLE;
                    valid_d  = 1'b1;
                    result_d = acc_next_c[NB_DATA-1:0];
                    ovf_d    = (acc_next_c[NB_PROD-1:NB_DATA] != {NB_DATA{acc_next_c[NB_DATA-1]}});
                    zero_d   = (acc_next_c[NB_DATA-1:0] == '0);
                end else begin
                    ready_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    // Every accepted opcode (MULT included) completes in one cycle
    always_comb begin
        ready_d  = 1'b1;
        valid_d  = 1'b0;
        result_d = result_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        if (accept_c) begin
            valid_d  = 1'b1;
            result_d = alu_r_c;
            ovf_d    = alu_ovf_c;
            zero_d   = (alu_r_c == '0);
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_result   = result_q;
    assign o_overflow = ovf_q;
    assign o_zero     = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes reference results, a negedge monitor pops on o_valid.
// Build with or without ALU_MULT_EN to match the RTL configuration.
module tb_alu_seq;

    localparam int N = 8;

    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_SUB  = 6'b100010;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_XOR  = 6'b100110;
    localparam logic [5:0] OP_NOR  = 6'b100111;
    localparam logic [5:0] OP_SLL  = 6'b000000;
    localparam logic [5:0] OP_SRL  = 6'b000010;
    localparam logic [5:0] OP_SRA  = 6'b000011;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_SLTU = 6'b101011;
    localparam logic [5:0] OP_MULT = 6'b011000;
    localparam logic [5:0] OP_UNK  = 6'b111111;

`ifdef ALU_MULT_EN
    localparam bit MULT_EN = 1'b1;
`else
    localparam bit MULT_EN = 1'b0;
`endif

    localparam int MAXS = (1 << (N - 1)) - 1;
    localparam int MINS = -(1 << (N - 1));

    logic         clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [N-1:0] i_data_a = '0;
    logic [N-1:0] i_data_b = '0;
    logic [5:0]   i_operation_code = '0;
    logic         o_valid;
    logic [N-1:0] o_result;
    logic         o_overflow;
    logic         o_zero;

    always #5 clk = ~clk;

    alu_seq #(.NB_DATA(N), .NB_OP(6)) dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_data_a         (i_data_a),
        .i_data_b         (i_data_b),
        .i_operation_code (i_operation_code),
        .o_valid          (o_valid),
        .o_result         (o_result),
        .o_overflow       (o_overflow),
        .o_zero           (o_zero)
    );

    typedef struct {
        logic [N-1:0] r;
        logic         ovf;
        logic         z;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   busy_until = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: true mathematical result, then truncate; overflow = not representable in N signed bits
    function automatic void ref_alu(input logic [5:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                    output logic [N-1:0] r, output logic ovf);
        int sa, sbv, ua, ub, full;
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        ua  = int'(a);
        ub  = int'(b);
        r   = '0;
        ovf = 1'b0;
        case (op)
            OP_ADD:  begin full = sa + sbv; r = N'(full); ovf = (full > MAXS) || (full < MINS); end
            OP_SUB:  begin full = sa - sbv; r = N'(full); ovf = (full > MAXS) || (full < MINS); end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_SLL:  r = (ub >= N) ? '0 : N'(ua << ub);
            OP_SRL:  r = (ub >= N) ? '0 : N'(ua >> ub);
            OP_SRA:  r = (ub >= N) ? ((sa < 0) ? '1 : '0) : N'(sa >>> ub);
            OP_SLT:  r = (sa < sbv) ? N'(1) : N'(0);
            OP_SLTU: r = (ua < ub) ? N'(1) : N'(0);
            OP_MULT: if (MULT_EN) begin
                full = sa * sbv; r = N'(full); ovf = (full > MAXS) || (full < MINS);
            end
            default: ;
        endcase
    endfunction

    // Drive one cycle of request; if the model says the DUT is ready, the request is accepted next edge
    task automatic issue(input logic [5:0] op, input logic [N-1:0] a, input logic [N-1:0] b, input bit v);
        exp_t e;
        @(posedge clk);
        #1;
        i_valid          = v;
        i_operation_code = op;
        i_data_a         = a;
        i_data_b         = b;
        if (v && cyc >= busy_until) begin
            ref_alu(op, a, b, e.r, e.ovf);
            e.z   = (e.r == '0);
            e.due = cyc + 1;
            if (op == OP_MULT && MULT_EN) begin
                e.due      = cyc + 1 + N;
                busy_until = e.due;
            end
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) issue(OP_SLL, '0, '0, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_result"},   o_result,   0);
        chk({tag, "_overflow"}, o_overflow, 0);
        chk({tag, "_zero"},     o_zero,     0);
        chk({tag, "_valid"},    o_valid,    0);
        chk({tag, "_ready"},    o_ready,    1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("ready", o_ready, (cyc >= busy_until) ? 1 : 0);
            if (o_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", o_valid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("latency",  cyc,        e.due);
                    chk("result",   o_result,   e.r);
                    chk("overflow", o_overflow, e.ovf);
                    chk("zero",     o_zero,     e.z);
                end
            end else if (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                chk("missing_valid", o_valid, 1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [14];
        logic [5:0] op;
        logic [N-1:0] a, b;
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL,
                OP_SRA, OP_SLT, OP_SLTU, OP_MULT, OP_UNK, 6'b000001};

        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;
        chk_reset_state("reset");
        mon_en = 1'b1;

        issue(OP_ADD, 8'd100, 8'd50, 1'b1);
        idle(2);
        issue(OP_SUB, 8'h80, 8'h01, 1'b1);
        issue(OP_AND, 8'h0F, 8'hF0, 1'b1);
        idle(1);
        issue(OP_SRA,  8'hF0, 8'd2, 1'b1);
        issue(OP_SRA,  8'hF0, 8'd9, 1'b1);
        issue(OP_SRL,  8'hF0, 8'd8, 1'b1);
        issue(OP_SLL,  8'h01, 8'd7, 1'b1);
        issue(OP_SLT,  8'hFF, 8'h01, 1'b1);
        issue(OP_SLTU, 8'hFF, 8'h01, 1'b1);
        issue(OP_UNK,  8'h12, 8'h34, 1'b1);
        issue(OP_MULT, 8'd3,  8'd3, 1'b1);
        idle(1);

        // 12 x -3, with requests offered while the multiplier is busy
        issue(OP_MULT, 8'd12, 8'hFD, 1'b1);
        issue(OP_ADD, 8'd1, 8'd2, 1'b1);
        issue(OP_XOR, 8'h55, 8'hAA, 1'b1);
        idle(4);
        issue(OP_OR, 8'h01, 8'h02, 1'b1);
        idle(4);
        issue(OP_MULT, 8'd16, 8'd16, 1'b1);
        idle(N + 2);

        // Reset lands on the 4th edge after the MULT is accepted
        issue(OP_MULT, 8'd5, 8'd7, 1'b1);
        idle(3);
        @(posedge clk);
        #1;
        i_reset = 1'b1;
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        i_reset    = 1'b0;
        sb.delete();
        busy_until = 0;
        chk_reset_state("midmul_reset");
        idle(N + 2);
        issue(OP_ADD, 8'd1, 8'd1, 1'b1);
        idle(2);

        for (int i = 0; i < 300; i++) begin
            op = ops[$urandom_range(0, 13)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            a = N'($urandom);
            b = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, N + 2)) : N'($urandom);
            issue(op, a, b, $urandom_range(0, 3) != 0);
        end

        idle(2 * N + 4);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
